seq_divider: RTL

Sequential restoring divider for the PE datapath: the inverse of the shift-add multiplier. It divides a 2*BITWIDTH-bit dividend by a BITWIDTH-bit divisor and produces a BITWIDTH-bit quotient and remainder. It resolves one quotient bit per fast_clk cycle. Overflow and divide-by-zero are detected at acceptance and return early.

---
 rtl/seq_divider.sv | 129 ++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2W-bit dividend by W-bit divisor, one quotient
// bit per fast_clk cycle, with overflow / divide-by-zero resolved at acceptance.
module seq_divider #(
  parameter int BITWIDTH = 8
) (
  input  logic                  fast_clk,
  input  logic                  rst,
  input  logic                  data_in_valid,
  output logic                  ready,
  input  logic [2*BITWIDTH-1:0] din1,
  input  logic [BITWIDTH-1:0]   din2,
  output logic                  data_out_valid,
  output logic [BITWIDTH-1:0]   quot,
  output logic [BITWIDTH-1:0]   rem,
  output logic                  ovf,
  output logic                  div_zero,
  output logic [1:0]            dbg_state_o
);

  localparam int CW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;

  // Handshake: a request is taken on a rising edge where data_in_valid=1 and
  // ready=1; data_out_valid is a one-cycle strobe and needs no acknowledge.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic [BITWIDTH-1:0] r_q;
  logic [BITWIDTH-1:0] sh_q;
  logic [BITWIDTH-1:0] dvsr_q;
  logic [CW-1:0]       cnt_q;
  logic                early_q;
  logic [BITWIDTH-1:0] quot_q;
  logic [BITWIDTH-1:0] rem_q;
  logic                ovf_q;
  logic                dz_q;
  logic                dov_q;

  // The W+1-bit trial holds the carry-out when the divisor MSB is set; the
  // surviving partial remainder is always below the divisor, so W bits store it.
  logic [BITWIDTH:0]   trial_d;
  logic                qbit_d;
  logic [BITWIDTH-1:0] diff_d;
  logic [BITWIDTH-1:0] r_d;
  logic [BITWIDTH-1:0] sh_d;
  logic [BITWIDTH-1:0] hi_d;
  logic [BITWIDTH-1:0] lo_d;
  logic                dz_in_d;
  logic                ovf_in_d;

  assign trial_d  = {r_q, sh_q[BITWIDTH-1]};
  assign qbit_d   = (trial_d >= {1'b0, dvsr_q});
  assign diff_d   = trial_d[BITWIDTH-1:0] - dvsr_q;
  assign r_d      = qbit_d ? diff_d : trial_d[BITWIDTH-1:0];
  assign sh_d     = {sh_q[BITWIDTH-2:0], qbit_d};

  assign hi_d     = din1[2*BITWIDTH-1:BITWIDTH];
  assign lo_d     = din1[BITWIDTH-1:0];
  assign dz_in_d  = (din2 == '0);
  assign ovf_in_d = dz_in_d || (hi_d >= din2);

  always_ff @(posedge fast_clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      sh_q    <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      early_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      dov_q   <= 1'b0;
    end else begin
      dov_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (data_in_valid) begin
            dvsr_q  <= din2;
            r_q     <= hi_d;
            sh_q    <= lo_d;
            cnt_q   <= CW'(BITWIDTH - 1);
            early_q <= ovf_in_d;
            ovf_q   <= ovf_in_d;
            dz_q    <= dz_in_d;
            state_q <= RUN;
            if (ovf_in_d) begin
              quot_q <= '1;
              rem_q  <= lo_d;
            end
          end
        end
        RUN: begin
          // Overflow passes through RUN once so its strobe lands one edge after acceptance.
          if (early_q) begin
            state_q <= DONE;
            dov_q   <= 1'b1;
          end else begin
            r_q  <= r_d;
            sh_q <= sh_d;
            if (cnt_q == '0) begin
              quot_q  <= sh_d;
              rem_q   <= r_d;
              state_q <= DONE;
              dov_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready          = (state_q == IDLE);
  assign data_out_valid = dov_q;
  assign quot           = quot_q;
  assign rem            = rem_q;
  assign ovf            = ovf_q;
  assign div_zero       = dz_q;
  assign dbg_state_o    = state_q;

endmodule
